// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter feeding one shared 32-bit SLL/SRA datapath.
// A single result register is delivered on a valid/ready handshake.

module shift_sll (
   input  logic [31:0] data,
   input  logic [4:0]  shamt,
   output logic [31:0] result
);

   // Logarithmic barrel: each shamt bit conditionally shifts by its weight.
   always_comb begin
      result = data;
      if (shamt[0]) result = {result[30:0], 1'b0};
      if (shamt[1]) result = {result[29:0], 2'b0};
      if (shamt[2]) result = {result[27:0], 4'b0};
      if (shamt[3]) result = {result[23:0], 8'b0};
      if (shamt[4]) result = {result[15:0], 16'b0};
   end

endmodule

module shift_sra (
   input  logic [31:0] data,
   input  logic [4:0]  shamt,
   output logic [31:0] result
);

   // The sign bit survives every stage, so result[31] is always the original sign.
   always_comb begin
      result = data;
      if (shamt[0]) result = {{1{result[31]}},  result[31:1]};
      if (shamt[1]) result = {{2{result[31]}},  result[31:2]};
      if (shamt[2]) result = {{4{result[31]}},  result[31:4]};
      if (shamt[3]) result = {{8{result[31]}},  result[31:8]};
      if (shamt[4]) result = {{16{result[31]}}, result[31:16]};
   end

endmodule

module shift_arbiter (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic        req0_op,
   input  logic [31:0] req0_data,
   input  logic [4:0]  req0_shamt,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic        req1_op,
   input  logic [31:0] req1_data,
   input  logic [4:0]  req1_shamt,
   output logic        res_valid,
   output logic        res_id,
   output logic [31:0] res_data,
   input  logic        res_ready
);

   logic        last_grant;
   logic        slot_free;
   logic        grant0;
   logic        grant1;
   logic        sel_op;
   logic [31:0] sel_data;
   logic [4:0]  sel_shamt;
   logic [31:0] sll_result;
   logic [31:0] sra_result;
   logic [31:0] shift_result;

   assign slot_free = !res_valid || res_ready;

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!reset && slot_free) begin
         if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Operand mux steers the granted requester into the one shared datapath.
   assign sel_op    = grant1 ? req1_op    : req0_op;
   assign sel_data  = grant1 ? req1_data  : req0_data;
   assign sel_shamt = grant1 ? req1_shamt : req0_shamt;

   shift_sll u_sll (
      .data   (sel_data),
      .shamt  (sel_shamt),
      .result (sll_result)
   );

   shift_sra u_sra (
      .data   (sel_data),
      .shamt  (sel_shamt),
      .result (sra_result)
   );

   assign shift_result = sel_op ? sra_result : sll_result;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock) begin
      if (reset) begin
         res_valid  <= 1'b0;
         res_id     <= 1'b0;
         res_data   <= 32'h0;
         last_grant <= 1'b1;
      end else if (grant0 || grant1) begin
         res_valid  <= 1'b1;
         res_id     <= grant1;
         res_data   <= shift_result;
         last_grant <= grant1;
      end else if (res_ready) begin
         res_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: directed vectors, then a long random run
// checked against a behavioural shift reference.

module tb_shift_arbiter;

   logic        clock;
   logic        reset;
   logic        req0_valid, req0_ready, req0_op;
   logic [31:0] req0_data;
   logic [4:0]  req0_shamt;
   logic        req1_valid, req1_ready, req1_op;
   logic [31:0] req1_data;
   logic [4:0]  req1_shamt;
   logic        res_valid, res_id, res_ready;
   logic [31:0] res_data;

   int checks   = 0;
   int failures = 0;

   logic [32:0] exp_q [$];
   logic        m_valid;
   logic        m_last;

   shift_arbiter dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_data  (req0_data),
      .req0_shamt (req0_shamt),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_data  (req1_data),
      .req1_shamt (req1_shamt),
      .res_valid  (res_valid),
      .res_id     (res_id),
      .res_data   (res_data),
      .res_ready  (res_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic op, input logic [31:0] d, input logic [4:0] s);
      if (op) return 32'($signed(d) >>> s);
      return d << s;
   endfunction

   // One bus cycle: drive after the falling edge, check readies, then cross the rising edge.
   task automatic cycle(input logic rst, input logic rr,
                        input logic v0, input logic o0, input logic [31:0] d0, input logic [4:0] s0,
                        input logic [31:0] e0,
                        input logic v1, input logic o1, input logic [31:0] d1, input logic [4:0] s1,
                        input logic [31:0] e1,
                        output logic g0, output logic g1);
      @(negedge clock);
      #1;
      reset = rst; res_ready = rr;
      req0_valid = v0; req0_op = o0; req0_data = d0; req0_shamt = s0;
      req1_valid = v1; req1_op = o1; req1_data = d1; req1_shamt = s1;
      #1;
      g0 = 1'b0; g1 = 1'b0;
      if (!rst && (!m_valid || rr)) begin
         if (v0 && v1) begin
            g0 = m_last; g1 = !m_last;
         end else begin
            g0 = v0; g1 = v1;
         end
      end
      check("req0_ready", {31'b0, req0_ready}, {31'b0, g0});
      check("req1_ready", {31'b0, req1_ready}, {31'b0, g1});
      if (rst) begin
         exp_q.delete();
         m_valid = 1'b0;
         m_last  = 1'b1;
      end else if (g0 || g1) begin
         exp_q.push_back({g1, g1 ? e1 : e0});
         m_valid = 1'b1;
         m_last  = g1;
      end else if (rr) begin
         m_valid = 1'b0;
      end
      @(posedge clock);
      #1;
   endtask

   // Monitor: a result is consumed whenever valid and ready meet before an edge.
   always @(negedge clock) begin
      logic [32:0] e;
      #2;
      if (!reset && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got id=%0d data=0x%08h required no result", res_id, res_data);
         end else begin
            e = exp_q.pop_front();
            check("res_id",   {31'b0, res_id}, {31'b0, e[32]});
            check("res_data", res_data, e[31:0]);
         end
      end
   end

   logic        g0, g1;
   logic        p0, p1, ro0, ro1;
   logic [31:0] rd0, rd1;
   logic [4:0]  rs0, rs1;
   int          ops;

   initial begin
      reset = 1'b1; res_ready = 1'b0;
      req0_valid = 0; req0_op = 0; req0_data = 0; req0_shamt = 0;
      req1_valid = 0; req1_op = 0; req1_data = 0; req1_shamt = 0;
      m_valid = 1'b0; m_last = 1'b1;

      repeat (2) cycle(1, 0, 0,0,0,0,0, 0,0,0,0,0, g0, g1);
      check("rst_res_valid", {31'b0, res_valid}, 0);
      check("rst_res_id",    {31'b0, res_id},    0);
      check("rst_res_data",  res_data,           0);

      // Single op and latency
      cycle(0, 1, 1,0,32'h0000_0001,5'd4,32'h0000_0010, 0,0,0,0,0, g0, g1);
      check("lat_res_valid", {31'b0, res_valid}, 1);
      check("lat_res_data",  res_data, 32'h0000_0010);
      cycle(0, 1, 0,0,0,0,0, 0,0,0,0,0, g0, g1);

      // Fill and boundary shift amounts, back to back
      cycle(0, 1, 0,0,0,0,0, 1,1,32'h8000_0000,5'd31,32'hFFFF_FFFF, g0, g1);
      cycle(0, 1, 0,0,0,0,0, 1,1,32'h7FFF_FFFF,5'd31,32'h0000_0000, g0, g1);
      cycle(0, 1, 1,0,32'hDEAD_BEEF,5'd0,32'hDEAD_BEEF, 0,0,0,0,0, g0, g1);
      cycle(0, 1, 0,0,0,0,0, 1,1,32'hDEAD_BEEF,5'd0,32'hDEAD_BEEF, g0, g1);
      cycle(0, 1, 1,0,32'hFFFF_FFFF,5'd31,32'h8000_0000, 0,0,0,0,0, g0, g1);
      cycle(0, 1, 0,0,0,0,0, 1,1,32'h8765_4321,5'd8,32'hFF87_6543, g0, g1);
      cycle(0, 1, 0,0,0,0,0, 0,0,0,0,0, g0, g1);

      // Round-robin from reset: 0,1,0,1
      cycle(1, 0, 0,0,0,0,0, 0,0,0,0,0, g0, g1);
      repeat (4) cycle(0, 1, 1,0,32'h3,5'd1,32'h6, 1,1,32'hF000_0000,5'd4,32'hFF00_0000, g0, g1);

      // Backpressure: result from requester 1 held for three cycles
      repeat (3) begin
         cycle(0, 0, 1,0,32'h3,5'd1,32'h6, 1,1,32'hF000_0000,5'd4,32'hFF00_0000, g0, g1);
         check("bp_res_valid", {31'b0, res_valid}, 1);
         check("bp_res_id",    {31'b0, res_id},    1);
         check("bp_res_data",  res_data, 32'hFF00_0000);
      end
      cycle(0, 1, 1,0,32'h3,5'd1,32'h6, 1,1,32'hF000_0000,5'd4,32'hFF00_0000, g0, g1);
      check("repl_res_valid", {31'b0, res_valid}, 1);
      check("repl_res_data",  res_data, 32'h6);

      // Reset mid-operation discards the pending result
      cycle(0, 0, 0,0,0,0,0, 1,0,32'h1,5'd1,32'h2, g0, g1);
      cycle(1, 0, 0,0,0,0,0, 1,0,32'h1,5'd1,32'h2, g0, g1);
      check("mid_rst_valid", {31'b0, res_valid}, 0);
      check("mid_rst_data",  res_data, 0);
      cycle(0, 1, 1,1,32'h8000_00F0,5'd4,32'hF800_000F, 1,0,32'h1,5'd1,32'h2, g0, g1);
      check("post_rst_id",   {31'b0, res_id}, 0);
      cycle(0, 1, 0,0,0,0,0, 0,0,0,0,0, g0, g1);

      // Random run: each requester holds its operation until granted
      p0 = 0; p1 = 0; ops = 0;
      ro0 = 0; ro1 = 0; rd0 = 0; rd1 = 0; rs0 = 0; rs1 = 0;
      for (int c = 0; c < 40000 && ops < 10000; c++) begin
         if (!p0 && $urandom_range(3) != 0) begin
            p0 = 1; ro0 = 1'($urandom); rd0 = $urandom; rs0 = 5'($urandom);
         end
         if (!p1 && $urandom_range(3) != 0) begin
            p1 = 1; ro1 = 1'($urandom); rd1 = $urandom; rs1 = 5'($urandom);
         end
         cycle(0, 1'($urandom_range(3) != 0),
               p0, ro0, rd0, rs0, ref_shift(ro0, rd0, rs0),
               p1, ro1, rd1, rs1, ref_shift(ro1, rd1, rs1), g0, g1);
         if (g0) begin p0 = 0; ops++; end
         if (g1) begin p1 = 0; ops++; end
      end
      check("rand_ops_reached", {31'b0, ops >= 10000}, 1);

      repeat (3) cycle(0, 1, 0,0,0,0,0, 0,0,0,0,0, g0, g1);
      check("queue_empty", exp_q.size(), 0);
      check("final_res_valid", {31'b0, res_valid}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
